// File: rtl/autoconfig_master.sv
`timescale 1ns/1ps
// autoconfig_master: Zorro II AutoConfig initiator. Runs 68000-style bus cycles
// into $E80000 config space, reads each board's type/size, assigns a naturally
// aligned base inside the eight 1MB slots at $200000-$9FFFFF (or shuts the board
// up), and repeats until no board answers or the write budget runs out.
// Ports:
//   CLK, reset       bus clock; asynchronous active-low reset
//   start, premap    run request pulse; slots already taken (sampled on start)
//   ADDR[23:1]       bus address
//   ASn/UDSn/LDSn    strobes (LDSn held high, config space is upper byte only)
//   RWn, DBUS[3:0]   direction; D15..D12, driven only for writes
//   CFGOUTn          chain enable to the first board, low while a run is active
//   busy/done/err    run status; err held until the next start
//   alloc_map/boards occupied slots and base writes issued this run
module autoconfig_master #(
  parameter int unsigned STROBE_CLKS  = 4,
  parameter int unsigned MAX_ATTEMPTS = 16
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  premap,
  output logic [23:1] ADDR,
  output logic        ASn,
  output logic        UDSn,
  output logic        LDSn,
  output logic        RWn,
  inout  wire  [3:0]  DBUS,
  output logic        CFGOUTn,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  alloc_map,
  output logic [3:0]  boards
);

  localparam int unsigned CNT_W = (STROBE_CLKS > 1) ? $clog2(STROBE_CLKS) : 1;
  localparam int unsigned ATT_W = $clog2(MAX_ATTEMPTS + 1);

  localparam logic [7:0] OFF_TYPE = 8'h00;
  localparam logic [7:0] OFF_SIZE = 8'h01;
  localparam logic [7:0] OFF_BASE = 8'h24;
  localparam logic [7:0] OFF_SHUT = 8'h26;

  typedef enum logic [1:0] {B_IDLE, B_ADDR, B_STRB, B_END} bus_state_e;
  typedef enum logic [2:0] {
    T_IDLE, T_R_TYPE, T_R_SIZE, T_DECIDE, T_W_BASE, T_W_SHUT, T_FINISH
  } top_state_e;

  bus_state_e        bus_state_q, bus_state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [23:1]       addr_q, addr_d;
  logic              rwn_q, rwn_d;
  logic              as_n_q, as_n_d;
  logic              oe_q, oe_d;
  logic [3:0]        dout_q, dout_d;
  logic [3:0]        rdata_q, rdata_d;

  top_state_e        top_state_q, top_state_d;
  logic              issued_q, issued_d;
  logic [7:0]        alloc_q, alloc_d;
  logic [3:0]        boards_q, boards_d;
  logic [ATT_W-1:0]  attempts_q, attempts_d;
  logic              err_q, err_d;
  logic              cfgoutn_q, cfgoutn_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [3:0]        n_q, n_d;
  logic [2:0]        base_q, base_d;
  logic [7:0]        mask_q, mask_d;

  logic              req_c, req_rwn_c;
  logic [7:0]        req_off_c;
  logic [3:0]        req_data_c;
  logic              cyc_done_c;
  logic              fit_found_c;
  logic [2:0]        fit_base_c;
  logic [7:0]        fit_mask_c;
  logic [7:0]        blk_c;

  assign cyc_done_c = (bus_state_q == B_END);

  // Bus request decoded from the top state; issued once per top-state visit
  always_comb begin
    req_c      = 1'b0;
    req_rwn_c  = 1'b1;
    req_off_c  = OFF_TYPE;
    req_data_c = 4'h0;
    case (top_state_q)
      T_R_TYPE: req_c = 1'b1;
      T_R_SIZE: begin
        req_c     = 1'b1;
        req_off_c = OFF_SIZE;
      end
      T_W_BASE: begin
        req_c      = 1'b1;
        req_rwn_c  = 1'b0;
        req_off_c  = OFF_BASE;
        req_data_c = {1'b0, base_q} + 4'd2;
      end
      T_W_SHUT: begin
        req_c     = 1'b1;
        req_rwn_c = 1'b0;
        req_off_c = OFF_SHUT;
      end
      default: ;
    endcase
    req_c = req_c && !issued_q && (bus_state_q == B_IDLE);
  end

  // Bus-cycle sequencer: address phase, strobe phase, hold phase
  always_comb begin
    bus_state_d = bus_state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rwn_d       = rwn_q;
    as_n_d      = as_n_q;
    oe_d        = oe_q;
    dout_d      = dout_q;
    rdata_d     = rdata_q;
    case (bus_state_q)
      B_IDLE: begin
        if (req_c) begin
          bus_state_d = B_ADDR;
          addr_d      = {8'hE8, 7'h00, req_off_c};
          rwn_d       = req_rwn_c;
          oe_d        = !req_rwn_c;
          dout_d      = req_data_c;
        end
      end
      B_ADDR: begin
        bus_state_d = B_STRB;
        as_n_d      = 1'b0;
        cnt_d       = '0;
      end
      B_STRB: begin
        if (cnt_q == CNT_W'(STROBE_CLKS - 1)) begin
          bus_state_d = B_END;
          as_n_d      = 1'b1;
          if (rwn_q) rdata_d = DBUS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      B_END: begin
        bus_state_d = B_IDLE;
        oe_d        = 1'b0;
        rwn_d       = 1'b1;
      end
      default: bus_state_d = B_IDLE;
    endcase
  end

  // Lowest naturally aligned free run of n_q slots in the current map
  always_comb begin
    fit_found_c = 1'b0;
    fit_base_c  = 3'd0;
    fit_mask_c  = 8'h00;
    blk_c       = 8'((9'd1 << n_q) - 9'd1);
    for (int s = 0; s < 8; s++) begin
      if (!fit_found_c && ((3'(s) & 3'(n_q - 4'd1)) == 3'd0) &&
          ((s + int'(n_q)) <= 8) && ((alloc_q & (blk_c << s)) == 8'h00)) begin
        fit_found_c = 1'b1;
        fit_base_c  = 3'(s);
        fit_mask_c  = blk_c << s;
      end
    end
  end

  // Run sequencer
  always_comb begin
    top_state_d = top_state_q;
    issued_d    = issued_q;
    alloc_d     = alloc_q;
    boards_d    = boards_q;
    attempts_d  = attempts_q;
    err_d       = err_q;
    cfgoutn_d   = cfgoutn_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    n_d         = n_q;
    base_d      = base_q;
    mask_d      = mask_q;
    if (req_c) issued_d = 1'b1;
    case (top_state_q)
      T_IDLE: begin
        if (start) begin
          alloc_d     = premap;
          boards_d    = 4'd0;
          attempts_d  = '0;
          err_d       = 1'b0;
          cfgoutn_d   = 1'b0;
          busy_d      = 1'b1;
          issued_d    = 1'b0;
          top_state_d = T_R_TYPE;
        end
      end
      T_R_TYPE: begin
        if (cyc_done_c) begin
          issued_d = 1'b0;
          if ((rdata_q == 4'hF) || (rdata_q[3:2] != 2'b11)) top_state_d = T_FINISH;
          else                                               top_state_d = T_R_SIZE;
        end
      end
      T_R_SIZE: begin
        if (cyc_done_c) begin
          issued_d = 1'b0;
          case (rdata_q[2:0])
            3'b000:  n_d = 4'd8;
            3'b111:  n_d = 4'd4;
            3'b110:  n_d = 4'd2;
            3'b101:  n_d = 4'd1;
            default: n_d = 4'd0;
          endcase
          top_state_d = (n_d == 4'd0) ? T_W_SHUT : T_DECIDE;
        end
      end
      T_DECIDE: begin
        if (fit_found_c) begin
          base_d      = fit_base_c;
          mask_d      = fit_mask_c;
          top_state_d = T_W_BASE;
        end else begin
          top_state_d = T_W_SHUT;
        end
      end
      T_W_BASE, T_W_SHUT: begin
        if (cyc_done_c) begin
          issued_d   = 1'b0;
          attempts_d = attempts_q + ATT_W'(1);
          if (top_state_q == T_W_BASE) begin
            alloc_d  = alloc_q | mask_q;
            boards_d = (boards_q == 4'hF) ? boards_q : boards_q + 4'd1;
          end
          if (attempts_d == ATT_W'(MAX_ATTEMPTS)) begin
            err_d       = 1'b1;
            top_state_d = T_FINISH;
          end else begin
            top_state_d = T_R_TYPE;
          end
        end
      end
      T_FINISH: begin
        cfgoutn_d   = 1'b1;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        top_state_d = T_IDLE;
      end
      default: top_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      bus_state_q <= B_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rwn_q       <= 1'b1;
      as_n_q      <= 1'b1;
      oe_q        <= 1'b0;
      dout_q      <= 4'h0;
      rdata_q     <= 4'h0;
      top_state_q <= T_IDLE;
      issued_q    <= 1'b0;
      alloc_q     <= 8'h00;
      boards_q    <= 4'd0;
      attempts_q  <= '0;
      err_q       <= 1'b0;
      cfgoutn_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      n_q         <= 4'd0;
      base_q      <= 3'd0;
      mask_q      <= 8'h00;
    end else begin
      bus_state_q <= bus_state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rwn_q       <= rwn_d;
      as_n_q      <= as_n_d;
      oe_q        <= oe_d;
      dout_q      <= dout_d;
      rdata_q     <= rdata_d;
      top_state_q <= top_state_d;
      issued_q    <= issued_d;
      alloc_q     <= alloc_d;
      boards_q    <= boards_d;
      attempts_q  <= attempts_d;
      err_q       <= err_d;
      cfgoutn_q   <= cfgoutn_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      n_q         <= n_d;
      base_q      <= base_d;
      mask_q      <= mask_d;
    end
  end

  assign ADDR      = addr_q;
  assign ASn       = as_n_q;
  assign UDSn      = as_n_q;
  assign LDSn      = 1'b1;
  assign RWn       = rwn_q;
  assign DBUS      = oe_q ? dout_q : 4'bz;
  assign CFGOUTn   = cfgoutn_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign alloc_map = alloc_q;
  assign boards    = boards_q;

endmodule

// File: tb/tb_autoconfig_master.sv
`timescale 1ns/1ps
// Scoreboarded bench for autoconfig_master: a board-chain responder answers
// config reads, a reference model predicts every bus cycle and the run result.
module tb_autoconfig_master;

  localparam int STROBE = 4;
  localparam int MAXATT = 16;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  premap;
  logic [23:1] ADDR;
  logic        ASn, UDSn, LDSn, RWn;
  wire  [3:0]  DBUS;
  logic        CFGOUTn, busy, done, err;
  logic [7:0]  alloc_map;
  logic [3:0]  boards;

  autoconfig_master #(.STROBE_CLKS(STROBE), .MAX_ATTEMPTS(MAXATT)) dut (
    .CLK(CLK), .reset(reset), .start(start), .premap(premap),
    .ADDR(ADDR), .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn), .RWn(RWn), .DBUS(DBUS),
    .CFGOUTn(CFGOUTn), .busy(busy), .done(done), .err(err),
    .alloc_map(alloc_map), .boards(boards)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic rwn; logic [7:0] off; logic [3:0] data; } cyc_t;
  typedef struct packed { logic [7:0] map; logic [3:0] nb; logic e; } fin_t;

  cyc_t exp_cyc[$];
  fin_t exp_fin[$];
  // Board chain: one entry per offer; last marks the final offer of a board
  logic [3:0] off_type[$];
  logic [3:0] off_size[$];
  bit         off_last[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_addr(input logic [7:0] off);
    return int'({8'hE8, 7'h00, off});
  endfunction

  function automatic int slots(input logic [3:0] sz);
    case (sz[2:0])
      3'b000:  return 8;
      3'b111:  return 4;
      3'b110:  return 2;
      3'b101:  return 1;
      default: return 0;
    endcase
  endfunction

  // ---------------- responder ----------------
  logic [3:0] cur_type = 4'hF, cur_size = 4'hF;
  logic       resp_en;
  logic [3:0] resp_val;
  logic       r_prev_asn = 1'b1;

  always_comb begin
    resp_en  = RWn && !ASn;
    resp_val = 4'hF;
    if (ADDR[8:1] == 8'h00)      resp_val = cur_type;
    else if (ADDR[8:1] == 8'h01) resp_val = cur_size;
  end
  assign DBUS = resp_en ? resp_val : 4'bz;

  always @(negedge CLK) begin
    if (reset && !r_prev_asn && ASn && !RWn) begin
      if (ADDR[8:1] == 8'h24) begin
        while (off_last.size() > 0 && !off_last[0]) begin
          void'(off_type.pop_front()); void'(off_size.pop_front()); void'(off_last.pop_front());
        end
      end
      if (off_last.size() > 0 && (ADDR[8:1] == 8'h24 || ADDR[8:1] == 8'h26)) begin
        void'(off_type.pop_front()); void'(off_size.pop_front()); void'(off_last.pop_front());
      end
    end
    r_prev_asn = ASn;
    cur_type   = (off_type.size() > 0) ? off_type[0] : 4'hF;
    cur_size   = (off_size.size() > 0) ? off_size[0] : 4'hF;
  end

  // ---------------- monitor ----------------
  logic        m_prev_asn = 1'b1;
  logic [23:1] m_prev_addr = '0;
  int          m_low = 0;
  bit          m_have = 1'b0;
  cyc_t        m_cur;
  fin_t        m_fin;

  always @(negedge CLK) begin
    if (mon_en && reset) begin
      if (m_prev_asn && !ASn) begin
        m_low = 1;
        if (exp_cyc.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_cycle: addr 0x%0h rwn %0d, none expected", ADDR, RWn);
          m_have = 1'b0;
        end else begin
          m_cur  = exp_cyc.pop_front();
          m_have = 1'b1;
          chk("addr", int'(ADDR), exp_addr(m_cur.off));
          chk("addr_setup", int'(m_prev_addr), exp_addr(m_cur.off));
          chk("rwn", int'(RWn), int'(m_cur.rwn));
          chk("uds_low", int'(UDSn), 0);
          chk("cfgout_low", int'(CFGOUTn), 0);
          if (!m_cur.rwn) chk("wdata", int'(DBUS), int'(m_cur.data));
          else            chk("rdata_bus", int'(DBUS), int'(resp_val));
        end
      end else if (!m_prev_asn && !ASn) begin
        m_low++;
      end else if (!m_prev_asn && ASn && m_have) begin
        chk("strobe_len", m_low, STROBE);
        chk("addr_hold", int'(ADDR), exp_addr(m_cur.off));
        chk("uds_high", int'(UDSn), 1);
        chk("lds", int'(LDSn), 1);
        if (!m_cur.rwn) chk("wdata_hold", int'(DBUS), int'(m_cur.data));
        m_have = 1'b0;
      end
      if (done) begin
        if (exp_fin.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: no run result expected");
        end else begin
          m_fin = exp_fin.pop_front();
          chk("alloc_map", int'(alloc_map), int'(m_fin.map));
          chk("boards", int'(boards), int'(m_fin.nb));
          chk("err", int'(err), int'(m_fin.e));
          chk("busy_at_done", int'(busy), 0);
        end
      end
    end
    m_prev_asn  = ASn;
    m_prev_addr = ADDR;
  end

  // ---------------- reference model ----------------
  task automatic push_cyc(input logic rwn, input logic [7:0] off, input logic [3:0] d);
    cyc_t c;
    c.rwn = rwn; c.off = off; c.data = d;
    exp_cyc.push_back(c);
  endtask

  task automatic model(input logic [7:0] pm);
    int map = int'(pm);
    int nb = 0, att = 0, h = 0, n, base;
    logic e = 1'b0;
    logic [3:0] ty;
    fin_t f;
    forever begin
      ty = (h < off_type.size()) ? off_type[h] : 4'hF;
      push_cyc(1'b1, 8'h00, ty);
      if (ty == 4'hF || ty[3:2] != 2'b11) break;
      push_cyc(1'b1, 8'h01, off_size[h]);
      n = slots(off_size[h]);
      base = -1;
      if (n > 0)
        for (int s = 0; s + n <= 8; s += n)
          if (((map >> s) & ((1 << n) - 1)) == 0) begin base = s; break; end
      if (base >= 0) begin
        push_cyc(1'b0, 8'h24, 4'(base + 2));
        map = map | (((1 << n) - 1) << base);
        if (nb < 15) nb++;
        while (h < off_last.size() && !off_last[h]) h++;
        h++;
      end else begin
        push_cyc(1'b0, 8'h26, 4'h0);
        h++;
      end
      att++;
      if (att == MAXATT) begin e = 1'b1; break; end
    end
    f.map = 8'(map); f.nb = 4'(nb); f.e = e;
    exp_fin.push_back(f);
  endtask

  // ---------------- stimulus ----------------
  task automatic add_offer(input logic [3:0] ty, input logic [3:0] sz, input bit last);
    off_type.push_back(ty); off_size.push_back(sz); off_last.push_back(last);
  endtask

  task automatic clear_offers();
    off_type.delete(); off_size.delete(); off_last.delete();
  endtask

  task automatic run_case(input logic [7:0] pm, input bit inject);
    int cnt = 0;
    model(pm);
    @(negedge CLK);
    premap = pm; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    while (!done && cnt < 3000) begin
      @(negedge CLK); cnt++;
      if (inject && cnt == 12 && busy && !done) begin
        start = 1'b1; premap = ~pm;
        @(negedge CLK); cnt++;
        start = 1'b0;
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: no done within %0d clocks", cnt);
    end
    @(negedge CLK);
    chk("done_pulse", int'(done), 0);
    chk("busy_idle", int'(busy), 0);
    chk("cfgout_idle", int'(CFGOUTn), 1);
    chk("cycles_left", exp_cyc.size(), 0);
    chk("results_left", exp_fin.size(), 0);
    exp_cyc.delete(); exp_fin.delete();
    clear_offers();
    @(negedge CLK);
  endtask

  function automatic logic [3:0] rand_size();
    int r = $urandom_range(0, 9);
    logic [2:0] c;
    case (r)
      0, 1:    c = 3'b000;
      2, 3:    c = 3'b111;
      4, 5:    c = 3'b110;
      6, 7:    c = 3'b101;
      8:       c = 3'b100;
      default: c = 3'b011;
    endcase
    return {1'($urandom_range(0, 1)), c};
  endfunction

  function automatic logic [3:0] rand_type();
    case ($urandom_range(0, 7))
      0:       return 4'h5;
      1, 2:    return 4'hC;
      3, 4:    return 4'hD;
      default: return 4'hE;
    endcase
  endfunction

  initial begin
    int w;
    reset = 1'b0; start = 1'b0; premap = 8'h00;
    #12;
    chk("rst_asn", int'(ASn), 1);
    chk("rst_uds", int'(UDSn), 1);
    chk("rst_lds", int'(LDSn), 1);
    chk("rst_rwn", int'(RWn), 1);
    chk("rst_addr", int'(ADDR), 0);
    chk("rst_cfgout", int'(CFGOUTn), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_alloc", int'(alloc_map), 0);
    chk("rst_boards", int'(boards), 0);
    @(negedge CLK); reset = 1'b1;
    @(negedge CLK); mon_en = 1'b1;

    // one 8M board into an empty map
    add_offer(4'hE, 4'h0, 1'b1);
    run_case(8'h00, 1'b0);
    // 8M refused, 4M placed above the premapped slots
    add_offer(4'hE, 4'h0, 1'b0); add_offer(4'hE, 4'h7, 1'b1);
    run_case(8'h03, 1'b0);
    // full map: every offer shut up, board goes quiet
    add_offer(4'hE, 4'h0, 1'b0); add_offer(4'hE, 4'h7, 1'b0);
    add_offer(4'hE, 4'h6, 1'b0); add_offer(4'hE, 4'h5, 1'b1);
    run_case(8'hFF, 1'b0);
    // unsupported size from a board that never releases: attempt limit
    for (int i = 0; i < 20; i++) add_offer(4'hE, 4'h4, i == 19);
    run_case(8'h00, 1'b0);
    // err clears on a fresh run; two boards share the map
    add_offer(4'hC, 4'h7, 1'b1); add_offer(4'hE, 4'h6, 1'b1);
    run_case(8'h10, 1'b0);

    // reset during the strobe phase of a cycle
    mon_en = 1'b0;
    add_offer(4'hE, 4'h0, 1'b1);
    @(negedge CLK); premap = 8'h00; start = 1'b1;
    @(negedge CLK); start = 1'b0;
    w = 0;
    while (ASn && w < 100) begin @(negedge CLK); w++; end
    chk("strobe_seen", int'(ASn), 0);
    @(negedge CLK);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_asn", int'(ASn), 1);
    chk("mid_rst_uds", int'(UDSn), 1);
    chk("mid_rst_rwn", int'(RWn), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_cfgout", int'(CFGOUTn), 1);
    chk("mid_rst_alloc", int'(alloc_map), 0);
    clear_offers(); exp_cyc.delete(); exp_fin.delete();
    @(negedge CLK); @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK); @(negedge CLK);
    mon_en = 1'b1;
    add_offer(4'hE, 4'h0, 1'b1);
    run_case(8'h00, 1'b0);

    // randomized board chains
    for (int it = 0; it < 30; it++) begin
      int nbd = $urandom_range(0, 3);
      for (int b = 0; b < nbd; b++) begin
        int no = $urandom_range(1, 3);
        logic [3:0] ty = rand_type();
        for (int o = 0; o < no; o++) add_offer(ty, rand_size(), o == no - 1);
      end
      run_case(8'($urandom_range(0, 255)), (it % 4) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
